gcd_ctrl_datapath: RTL and testbench

- Subtraction-based GCD engine for the GCD project: two WIDTH-bit operand registers, a compare/subtract unit and a controller FSM.
- It sits directly upstream of the 4-bit load/hold result registers, driving their data and load strobes.
- It accepts an operand pair on a start pulse, iterates one subtract per clock, and presents the result with a one-cycle done pulse.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_sub_cmp.sv | 24 ++
 rtl/gcd_ctrl_datapath.sv | 122 ++++++++++++
 tb/tb_gcd_ctrl_datapath.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and default sizes for the subtraction-based GCD engine.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GCD_WIDTH = 4;
    localparam int GCD_CNT_W = 8;

endpackage

// File: rtl/gcd_sub_cmp.sv
// Compare/subtract unit: zero tests, equality, magnitude and both differences.
// Latency: purely combinational. Backpressure: none.
module gcd_sub_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    output logic             a_zero,
    output logic             b_zero,
    output logic             eq,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] diff_ab,
    output logic [WIDTH-1:0] diff_ba
);

    assign a_zero  = (reg_a == '0);
    assign b_zero  = (reg_b == '0);
    assign eq      = (reg_a == reg_b);
    assign a_gt_b  = (reg_a > reg_b);
    // Only the difference selected by a_gt_b is ever used, so neither underflows in practice.
    assign diff_ab = reg_a - reg_b;
    assign diff_ba = reg_b - reg_a;

endmodule

// File: rtl/gcd_ctrl_datapath.sv
// GCD engine: operand registers plus IDLE/RUN/DONE controller; optional GCD_ITER_CNT_EN iteration counter.
// Latency: done pulses N+2 cycles after the start-sampling cycle (N = subtractions).
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped.
module gcd_ctrl_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
`ifdef GCD_ITER_CNT_EN
    , parameter int CNT_W = GCD_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             ld_res
`ifdef GCD_ITER_CNT_EN
    , output logic [CNT_W-1:0] iter_cnt
`endif
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic [WIDTH-1:0] result;
    logic             sub_en;
    logic             a_zero;
    logic             b_zero;
    logic             eq;
    logic             a_gt_b;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    gcd_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
        .reg_a   (reg_a),
        .reg_b   (reg_b),
        .a_zero  (a_zero),
        .b_zero  (b_zero),
        .eq      (eq),
        .a_gt_b  (a_gt_b),
        .diff_ab (diff_ab),
        .diff_ba (diff_ba)
    );

    always_comb begin
        next_state = state;
        next_a     = reg_a;
        next_b     = reg_b;
        result     = '0;
        sub_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_a     = a_in;
                    next_b     = b_in;
                    next_state = RUN;
                end
            end
            RUN: begin
                // Zero checks first so gcd(0,x) and gcd(x,0) terminate without looping.
                if (a_zero) begin
                    result     = reg_b;
                    next_state = DONE;
                end else if (b_zero || eq) begin
                    result     = reg_a;
                    next_state = DONE;
                end else if (a_gt_b) begin
                    next_a = diff_ab;
                    sub_en = 1'b1;
                end else begin
                    next_b = diff_ba;
                    sub_en = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            reg_a   <= '0;
            reg_b   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gcd_out <= '0;
        end else begin
            state <= next_state;
            reg_a <= next_a;
            reg_b <= next_b;
            busy  <= (next_state != IDLE);
            done  <= (next_state == DONE);
            if (state == RUN && next_state == DONE) begin
                gcd_out <= result;
            end
        end
    end

    assign ld_res = done;

`ifdef GCD_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_cnt <= '0;
        end else if (state == IDLE && start) begin
            iter_cnt <= '0;
        end else if (sub_en && iter_cnt != {CNT_W{1'b1}}) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_ctrl_datapath.sv
// Testbench for gcd_ctrl_datapath: table of operand pairs with expected result/latency, plus abort and overlap sequences.
module tb_gcd_ctrl_datapath;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] g;
        int         lat;
        int         iters;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        int         lat;
        int         iters;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [3:0] gcd_out;
    logic       ld_res;
`ifdef GCD_ITER_CNT_EN
    logic [7:0] iter_cnt;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t tbl[12];

    gcd_ctrl_datapath dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .ld_res  (ld_res)
`ifdef GCD_ITER_CNT_EN
        , .iter_cnt (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Drive one start at the negedge; the next posedge is cycle 0.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input bit push,
                         input logic [3:0] g, input int lat, input int iters);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        if (push) begin
            e.g = g; e.lat = lat; e.iters = iters;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 4'($urandom_range(0, 15));
        b_in  = 4'($urandom_range(0, 15));
    endtask

    // Wait for done, pop the scoreboard and compare result, timing and pulse width.
    task automatic collect(input string tag);
        exp_t e;
        int   cyc       = 0;
        int   busy_errs = 0;
        bit   got       = 0;
        logic [3:0] held;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b1) busy_errs++;
            if (done === 1'b1) got = 1;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_done_seen"}, 32'(got), 1);
        if (!got) return;
        chk({tag, "_latency"}, cyc, e.lat);
        chk({tag, "_gcd"}, 32'(gcd_out), 32'(e.g));
        chk({tag, "_ld_res"}, 32'(ld_res), 1);
        chk({tag, "_busy_run"}, busy_errs, 0);
`ifdef GCD_ITER_CNT_EN
        chk({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(e.iters));
`endif
        held = gcd_out;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'd0, done, ld_res}, 0);
        chk({tag, "_idle_after"}, 32'(busy), 0);
        chk({tag, "_gcd_hold"}, 32'(gcd_out), 32'(held));
    endtask

    initial begin
        int ndone;
        int first_cyc;
        int busy_seen;

        tbl[0]  = '{4'd12, 4'd8,  4'd4, 4,  2};
        tbl[1]  = '{4'd0,  4'd5,  4'd5, 2,  0};
        tbl[2]  = '{4'd9,  4'd9,  4'd9, 2,  0};
        tbl[3]  = '{4'd0,  4'd0,  4'd0, 2,  0};
        tbl[4]  = '{4'd15, 4'd1,  4'd1, 16, 14};
        tbl[5]  = '{4'd5,  4'd0,  4'd5, 2,  0};
        tbl[6]  = '{4'd1,  4'd15, 4'd1, 16, 14};
        tbl[7]  = '{4'd7,  4'd3,  4'd1, 6,  4};
        tbl[8]  = '{4'd8,  4'd12, 4'd4, 4,  2};
        tbl[9]  = '{4'd10, 4'd4,  4'd2, 5,  3};
        tbl[10] = '{4'd9,  4'd6,  4'd3, 4,  2};
        tbl[11] = '{4'd0,  4'd7,  4'd7, 2,  0};

        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_ld_res", 32'(ld_res), 0);
        chk("reset_gcd", 32'(gcd_out), 0);
`ifdef GCD_ITER_CNT_EN
        chk("reset_iter_cnt", 32'(iter_cnt), 0);
`endif

        for (int i = 0; i < 12; i++) begin
            issue(tbl[i].a, tbl[i].b, 1'b1, tbl[i].g, tbl[i].lat, tbl[i].iters);
            collect($sformatf("vec%0d", i));
        end

        // Second start during RUN must be dropped.
        issue(4'd6, 4'd4, 1'b0, 4'd0, 0, 0);
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd15;
        b_in  = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first_cyc = 0;
        for (int c = 2; c <= 24; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (first_cyc == 0) begin
                    first_cyc = c;
                    chk("overlap_gcd", 32'(gcd_out), 2);
                end
            end
        end
        chk("overlap_done_count", ndone, 1);
        chk("overlap_latency", first_cyc, 4);

        // Reset mid-computation aborts with no done.
        issue(4'd14, 4'd3, 1'b0, 4'd0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ld_res", 32'(ld_res), 0);
        chk("abort_gcd", 32'(gcd_out), 0);
`ifdef GCD_ITER_CNT_EN
        chk("abort_iter_cnt", 32'(iter_cnt), 0);
`endif
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        issue(4'd10, 4'd4, 1'b1, 4'd2, 5, 3);
        collect("after_abort");

        // Reset and start together: operands never captured.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        a_in  = 4'd7;
        b_in  = 4'd7;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        ndone = 0;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) busy_seen++;
        end
        chk("rst_start_busy", busy_seen, 0);
        chk("rst_start_done", ndone, 0);
        chk("rst_start_gcd", 32'(gcd_out), 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
